// File: rtl/stdp_seq_pkg.sv
// Shared definitions for the spike frame sequencer: sequencer states and default sizing.
package stdp_seq_pkg;

  localparam int DEF_NUM_SPIKES   = 16;
  localparam int DEF_TIME_W       = 5;
  localparam int DEF_TRAIN_PERIOD = 24;
  localparam int DEF_TEST_PERIOD  = 8;
  localparam int DEF_NEUR_W       = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    WAIT_RES = 2'd2
  } seq_state_e;

  // Completed-frame counter step; wraps naturally at 16 bits.
  function automatic logic [15:0] inc_wrap16(input logic [15:0] v);
    return v + 16'd1;
  endfunction

endpackage

// File: rtl/spike_frame_buf.sv
// One-entry valid/ready holding buffer for an offered spike frame plus its mode bit.
module spike_frame_buf #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_pop_i,
  output logic [DATA_W-1:0] out_data_o
);

  logic              full_q, full_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              push_s;

  // Ready is forced low during reset so nothing is taken while the block is cleared.
  assign in_ready_o  = ~full_q & ~rst;
  assign push_s      = in_valid_i & in_ready_o;
  assign out_valid_o = full_q;
  assign out_data_o  = data_q;

  // Next-state for the single slot; push only when empty, pop only when full.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (push_s) begin
      full_d = 1'b1;
      data_d = in_data_i;
    end else if (out_pop_i) begin
      full_d = 1'b0;
    end else begin
      full_d = full_q;
    end
  end

  // Slot registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/spike_frame_sequencer.sv
// Plays buffered spike-time frames one time step per cycle and collects the test-frame winner.
// Build option: define SPIKE_NO_FIRE_EN to treat an all-ones channel time as "never spikes".
module spike_frame_sequencer
  import stdp_seq_pkg::*;
#(
  parameter int NUM_SPIKES   = DEF_NUM_SPIKES,
  parameter int TIME_W       = DEF_TIME_W,
  parameter int TRAIN_PERIOD = DEF_TRAIN_PERIOD,
  parameter int TEST_PERIOD  = DEF_TEST_PERIOD,
  parameter int NEUR_W       = DEF_NEUR_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         training,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_SPIKES*TIME_W-1:0] in_spike_times,
  output logic [TIME_W-1:0]            time_val,
  output logic [NUM_SPIKES-1:0]        spikes_now,
  output logic                         frame_active,
  output logic                         frame_training,
  input  logic [NEUR_W-1:0]            winning_neuron,
  output logic                         result_valid,
  input  logic                         result_ready,
  output logic [NEUR_W-1:0]            result_neuron,
  output logic [15:0]                  frame_count
);

  localparam int                 TIMES_W    = NUM_SPIKES * TIME_W;
  localparam int                 BUF_W      = TIMES_W + 1;
  localparam logic [TIME_W-1:0]  TRAIN_LAST = TIME_W'(TRAIN_PERIOD - 1);
  localparam logic [TIME_W-1:0]  TEST_LAST  = TIME_W'(TEST_PERIOD - 1);

  if ((TEST_PERIOD < 1) || (TRAIN_PERIOD > (2 ** TIME_W))) begin : g_bad_params
    $error("spike_frame_sequencer: need 1 <= TEST_PERIOD and TRAIN_PERIOD <= 2**TIME_W");
  end

  seq_state_e          state_q, state_d;
  logic [TIME_W-1:0]   time_q, time_d;
  logic [TIMES_W-1:0]  times_q, times_d;
  logic                train_q, train_d;
  logic                res_valid_q, res_valid_d;
  logic [NEUR_W-1:0]   res_neuron_q, res_neuron_d;
  logic [15:0]         count_q, count_d;

  logic                buf_full_s;
  logic [BUF_W-1:0]    buf_data_s;
  logic                load_s;
  logic                capture_s;
  logic                done_s;
  logic [TIME_W-1:0]   last_time_s;

  spike_frame_buf #(
    .DATA_W(BUF_W)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  ({training, in_spike_times}),
    .out_valid_o(buf_full_s),
    .out_pop_i  (load_s),
    .out_data_o (buf_data_s)
  );

  // Period is a property of the active frame, never of the live training input.
  assign last_time_s = train_q ? TRAIN_LAST : TEST_LAST;

`ifdef SPIKE_NO_FIRE_EN
  function automatic logic chan_fires(input logic [TIME_W-1:0] t_ch, input logic [TIME_W-1:0] now);
    return (t_ch == now) && (t_ch != {TIME_W{1'b1}});
  endfunction
`else
  function automatic logic chan_fires(input logic [TIME_W-1:0] t_ch, input logic [TIME_W-1:0] now);
    return (t_ch == now);
  endfunction
`endif

  // Sequencer next-state: step time, resolve the result slot, chain or retire frames.
  always_comb begin
    state_d      = state_q;
    time_d       = time_q;
    times_d      = times_q;
    train_d      = train_q;
    res_valid_d  = res_valid_q;
    res_neuron_d = res_neuron_q;
    count_d      = count_q;
    load_s       = 1'b0;
    capture_s    = 1'b0;
    done_s       = 1'b0;

    case (state_q)
      IDLE: begin
        load_s = buf_full_s;
      end
      RUN: begin
        if (time_q != last_time_s) begin
          time_d = time_q + TIME_W'(1);
        end else if (train_q) begin
          done_s = 1'b1;
        end else if (!res_valid_q || result_ready) begin
          capture_s = 1'b1;
          done_s    = 1'b1;
        end else begin
          state_d = WAIT_RES;
        end
      end
      WAIT_RES: begin
        if (result_ready) begin
          capture_s = 1'b1;
          done_s    = 1'b1;
        end else begin
          state_d = WAIT_RES;
        end
      end
      default: begin
        state_d = IDLE;
        time_d  = '0;
      end
    endcase

    // A waiting buffered frame starts on the very next cycle, without an idle bubble.
    if (done_s) begin
      count_d = inc_wrap16(count_q);
      if (buf_full_s) begin
        load_s = 1'b1;
      end else begin
        state_d = IDLE;
        time_d  = '0;
      end
    end else begin
      count_d = count_q;
    end

    if (load_s) begin
      state_d = RUN;
      time_d  = '0;
      times_d = buf_data_s[TIMES_W-1:0];
      train_d = buf_data_s[BUF_W-1];
    end else begin
      times_d = times_q;
    end

    if (capture_s) begin
      res_valid_d  = 1'b1;
      res_neuron_d = winning_neuron;
    end else if (result_ready) begin
      res_valid_d = 1'b0;
    end else begin
      res_valid_d = res_valid_q;
    end
  end

  // Sequencer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      time_q       <= '0;
      times_q      <= '0;
      train_q      <= 1'b0;
      res_valid_q  <= 1'b0;
      res_neuron_q <= '0;
      count_q      <= 16'd0;
    end else begin
      state_q      <= state_d;
      time_q       <= time_d;
      times_q      <= times_d;
      train_q      <= train_d;
      res_valid_q  <= res_valid_d;
      res_neuron_q <= res_neuron_d;
      count_q      <= count_d;
    end
  end

  // Spike pulses only while stepping; a stalled frame holds its last time silently.
  always_comb begin
    spikes_now = '0;
    for (int i = 0; i < NUM_SPIKES; i++) begin
      spikes_now[i] = (state_q == RUN) && chan_fires(times_q[i*TIME_W +: TIME_W], time_q);
    end
  end

  assign time_val       = time_q;
  assign frame_active   = (state_q != IDLE);
  assign frame_training = train_q;
  assign result_valid   = res_valid_q;
  assign result_neuron  = res_neuron_q;
  assign frame_count    = count_q;

endmodule

// File: tb/tb_spike_frame_sequencer.sv
// Self-checking bench: table of single frames, directed multi-cycle cases, random run vs reference model.
module tb_spike_frame_sequencer;

  localparam int NS      = 16;
  localparam int TW      = 5;
  localparam int NW      = 4;
  localparam int TRAIN_P = 24;
  localparam int TEST_P  = 8;

  logic            clk, rst, training, in_valid, in_ready, result_ready, result_valid;
  logic [NS*TW-1:0] in_spike_times;
  logic [TW-1:0]   time_val;
  logic [NS-1:0]   spikes_now;
  logic            frame_active, frame_training;
  logic [NW-1:0]   winning_neuron, result_neuron;
  logic [15:0]     frame_count;

  logic            d32_in_ready, d32_act, d32_tr, d32_rv;
  logic [TW-1:0]   d32_time;
  logic [NS-1:0]   d32_spikes;
  logic [NW-1:0]   d32_rn;
  logic [15:0]     d32_cnt;

  spike_frame_sequencer dut (
    .clk(clk), .rst(rst), .training(training), .in_valid(in_valid), .in_ready(in_ready),
    .in_spike_times(in_spike_times), .time_val(time_val), .spikes_now(spikes_now),
    .frame_active(frame_active), .frame_training(frame_training), .winning_neuron(winning_neuron),
    .result_valid(result_valid), .result_ready(result_ready), .result_neuron(result_neuron),
    .frame_count(frame_count));

  spike_frame_sequencer #(.TRAIN_PERIOD(32)) dut32 (
    .clk(clk), .rst(rst), .training(training), .in_valid(in_valid), .in_ready(d32_in_ready),
    .in_spike_times(in_spike_times), .time_val(d32_time), .spikes_now(d32_spikes),
    .frame_active(d32_act), .frame_training(d32_tr), .winning_neuron(winning_neuron),
    .result_valid(d32_rv), .result_ready(result_ready), .result_neuron(d32_rn),
    .frame_count(d32_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame-level rules) ----------------
  bit              m_act, m_wait, m_train, m_bfull, m_btrain, m_rv;
  int              m_t;
  logic [NW-1:0]   m_rn;
  logic [15:0]     m_cnt;
  logic [NS*TW-1:0] m_times, m_btimes;
  bit              m_acc, m_last, m_cap, m_done, m_stall, m_start;
  int              m_p;

  always_comb begin
    m_p     = m_train ? TRAIN_P : TEST_P;
    m_acc   = in_valid && !m_bfull && !rst;
    m_last  = m_act && !m_wait && (m_t == m_p - 1);
    m_cap   = m_act && !m_train && ((m_last && (!m_rv || result_ready)) || (m_wait && result_ready));
    m_done  = m_cap || (m_last && m_train);
    m_stall = m_last && !m_train && m_rv && !result_ready;
    m_start = m_bfull && (!m_act || m_done);
  end

  always @(posedge clk) begin
    if (rst) begin
      m_act <= 1'b0; m_wait <= 1'b0; m_train <= 1'b0; m_bfull <= 1'b0; m_btrain <= 1'b0;
      m_rv <= 1'b0; m_t <= 0; m_rn <= '0; m_cnt <= 16'd0; m_times <= '0; m_btimes <= '0;
    end else begin
      m_bfull <= m_acc || (m_bfull && !m_start);
      if (m_acc) begin
        m_btrain <= training;
        m_btimes <= in_spike_times;
      end
      if (m_start) begin
        m_act <= 1'b1; m_t <= 0; m_wait <= 1'b0; m_train <= m_btrain; m_times <= m_btimes;
      end else if (m_done) begin
        m_act <= 1'b0; m_t <= 0; m_wait <= 1'b0;
      end else if (m_stall) begin
        m_wait <= 1'b1;
      end else if (m_act && !m_wait) begin
        m_t <= m_t + 1;
      end
      if (m_done) m_cnt <= m_cnt + 16'd1;
      m_rv <= m_cap || (m_rv && !result_ready);
      if (m_cap) m_rn <= winning_neuron;
    end
  end

  function automatic logic [NS-1:0] exp_spikes();
    logic [NS-1:0] s;
    s = '0;
    for (int i = 0; i < NS; i++) begin
      logic [TW-1:0] c;
      c = m_times[i*TW +: TW];
      if (m_act && !m_wait && (int'(c) == m_t)) begin
`ifdef SPIKE_NO_FIRE_EN
        if (c != 5'd31) s[i] = 1'b1;
`else
        s[i] = 1'b1;
`endif
      end
    end
    return s;
  endfunction

  // Every cycle: all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en)
        chk("model_cycle",
            {in_ready, time_val, spikes_now, frame_active, frame_training, result_valid, result_neuron, frame_count},
            {(!m_bfull && !rst), TW'(m_t), exp_spikes(), m_act, m_train, m_rv, m_rn, m_cnt});
    end
  end

  // ---------------- stimulus helpers ----------------
  typedef struct { bit train; logic [NS*TW-1:0] times; } frame_t;
  frame_t offer_q[$];

  int act_cyc, rv_cyc, tr_cyc, first_act, lk;
  int s0_n, s0_t, s1_n, s1_t, d_s0_n, d_s0_t, d_s1_n;
  int tv_log[$];

  task automatic clr_log();
    act_cyc = 0; rv_cyc = 0; tr_cyc = 0; first_act = -1; lk = 0;
    s0_n = 0; s0_t = -1; s1_n = 0; s1_t = -1; d_s0_n = 0; d_s0_t = -1; d_s1_n = 0;
    tv_log.delete();
  endtask

  function automatic logic [NS*TW-1:0] mk_times(input int t0, input int t1);
    logic [NS*TW-1:0] v;
    for (int i = 0; i < NS; i++) v[i*TW +: TW] = TW'($urandom_range(0, 31));
    v[0 +: TW]  = TW'(t0);
    v[TW +: TW] = TW'(t1);
    return v;
  endfunction

  // Runs ncyc cycles from just after a rising edge, offering queued frames and logging outputs.
  task automatic run(input int ncyc, input bit rr);
    bit acc;
    result_ready = rr;
    for (int k = 0; k < ncyc; k++) begin
      if (offer_q.size() > 0) begin
        in_valid = 1'b1; training = offer_q[0].train; in_spike_times = offer_q[0].times;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      if (frame_active) begin
        if (first_act < 0) first_act = lk;
        act_cyc++;
        tv_log.push_back(int'(time_val));
        if (frame_training) tr_cyc++;
      end
      if (result_valid) rv_cyc++;
      if (spikes_now[0]) begin s0_n++; s0_t = int'(time_val); end
      if (spikes_now[1]) begin s1_n++; s1_t = int'(time_val); end
      if (d32_spikes[0]) begin d_s0_n++; d_s0_t = int'(d32_time); end
      if (d32_spikes[1]) d_s1_n++;
      lk++;
      @(posedge clk); #1;
      if (acc) void'(offer_q.pop_front());
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; offer_q.delete();
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_outputs",
        {in_ready, time_val, spikes_now, frame_active, frame_training, result_valid, result_neuron, frame_count}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", in_ready, 64'd1);
    @(posedge clk); #1;
  endtask

  typedef struct { bit train; int t0; int t1; int win; int len; int s0; int s1; int rv; int rn; } vec_t;
  vec_t vecs[5];

  initial begin
    int errs;
    int exp_d_n, exp_d_t;
    rst = 1'b1; in_valid = 1'b0; training = 1'b0; result_ready = 1'b1;
    in_spike_times = '0; winning_neuron = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;

    // Single frames, result_ready held high: {train,t0,t1,win, len,s0,s1,rv_cycles,final_result}
    vecs[0] = '{1'b0,  3,  7,  5,  8,  3,  7, 1,  5};
    vecs[1] = '{1'b0,  0, 31,  9,  8,  0, -1, 1,  9};
    vecs[2] = '{1'b1, 23, 12,  4, 24, 23, 12, 0,  0};
    vecs[3] = '{1'b0,  8,  7, 15,  8, -1,  7, 1, 15};
    vecs[4] = '{1'b1, 24,  0,  3, 24, -1,  0, 0,  0};
    for (int v = 0; v < 5; v++) begin
      do_reset();
      clr_log();
      winning_neuron = NW'(vecs[v].win);
      offer_q.push_back('{vecs[v].train, mk_times(vecs[v].t0, vecs[v].t1)});
      run(40, 1'b1);
      chk($sformatf("v%0d_start_latency", v), first_act, 2);
      chk($sformatf("v%0d_active_cycles", v), act_cyc, vecs[v].len);
      chk($sformatf("v%0d_ch0_pulses", v), s0_n, (vecs[v].s0 >= 0) ? 1 : 0);
      chk($sformatf("v%0d_ch0_time", v), s0_t, vecs[v].s0);
      chk($sformatf("v%0d_ch1_pulses", v), s1_n, (vecs[v].s1 >= 0) ? 1 : 0);
      chk($sformatf("v%0d_ch1_time", v), s1_t, vecs[v].s1);
      chk($sformatf("v%0d_result_cycles", v), rv_cyc, vecs[v].rv);
      chk($sformatf("v%0d_result_neuron", v), result_neuron, vecs[v].rn);
      chk($sformatf("v%0d_frame_count", v), frame_count, 1);
    end

    // Two training frames back to back: 0..23 twice with no gap, no result.
    do_reset();
    clr_log();
    offer_q.push_back('{1'b1, mk_times(2, 9)});
    offer_q.push_back('{1'b1, mk_times(4, 30)});
    run(60, 1'b1);
    errs = 0;
    for (int i = 0; i < tv_log.size(); i++) if (tv_log[i] != (i % 24)) errs++;
    chk("t2_active_cycles", act_cyc, 48);
    chk("t2_time_sequence_errs", errs, 0);
    chk("t2_result_cycles", rv_cyc, 0);
    chk("t2_frame_count", frame_count, 2);

    // Two testing frames with result_ready low: second stalls at its last step.
    do_reset();
    clr_log();
    winning_neuron = 4'd6;
    offer_q.push_back('{1'b0, mk_times(1, 2)});
    offer_q.push_back('{1'b0, mk_times(3, 4)});
    run(14, 1'b0);
    winning_neuron = 4'd11;
    run(8, 1'b0);
    @(negedge clk);
    chk("t3_stall_active", frame_active, 1);
    chk("t3_stall_time", time_val, 7);
    chk("t3_stall_spikes", spikes_now, 0);
    chk("t3_stall_result", {result_valid, result_neuron}, {1'b1, 4'd6});
    chk("t3_stall_count", frame_count, 1);
    @(posedge clk); #1;
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    @(negedge clk);
    chk("t3_release_result", {result_valid, result_neuron}, {1'b1, 4'd11});
    chk("t3_release_idle", frame_active, 0);
    chk("t3_release_count", frame_count, 2);
    @(posedge clk); #1;

    // Reset at time_val=5 with the buffer full discards everything.
    do_reset();
    clr_log();
    offer_q.push_back('{1'b0, mk_times(5, 6)});
    offer_q.push_back('{1'b0, mk_times(0, 1)});
    run(7, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("t4_time_at_reset", time_val, 5);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_outputs_cleared",
        {in_ready, time_val, spikes_now, frame_active, frame_training, result_valid, result_neuron, frame_count}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t4_ready_after_release", in_ready, 1);
    @(posedge clk); #1;
    clr_log();
    run(6, 1'b1);
    chk("t4_no_replay", act_cyc, 0);

    // All-ones channel time on a 32-step training frame.
    do_reset();
    clr_log();
    offer_q.push_back('{1'b1, mk_times(31, 5)});
    run(40, 1'b1);
`ifdef SPIKE_NO_FIRE_EN
    exp_d_n = 0; exp_d_t = -1;
`else
    exp_d_n = 1; exp_d_t = 31;
`endif
    chk("t5_p32_ch0_pulses", d_s0_n, exp_d_n);
    chk("t5_p32_ch0_time", d_s0_t, exp_d_t);
    chk("t5_p32_ch1_pulses", d_s1_n, 1);
    chk("t5_p24_ch0_pulses", s0_n, 0);

    // Training toggled mid-frame: current frame keeps 24 steps, next one runs 8.
    do_reset();
    clr_log();
    winning_neuron = 4'd13;
    offer_q.push_back('{1'b1, mk_times(10, 20)});
    run(6, 1'b1);
    offer_q.push_back('{1'b0, mk_times(2, 6)});
    run(40, 1'b1);
    errs = 0;
    for (int i = 0; i < tv_log.size(); i++) if (tv_log[i] != ((i < 24) ? i : (i - 24))) errs++;
    chk("t6_active_cycles", act_cyc, 32);
    chk("t6_time_sequence_errs", errs, 0);
    chk("t6_training_cycles", tr_cyc, 24);
    chk("t6_result", {rv_cyc[3:0], result_neuron}, {4'd1, 4'd13});
    chk("t6_frame_count", frame_count, 2);

    // Random traffic against the reference model.
    for (int k = 0; k < 3000; k++) begin
      rst      = ($urandom_range(0, 199) == 0);
      in_valid = 1'($urandom_range(0, 1));
      training = 1'($urandom_range(0, 1));
      for (int i = 0; i < NS; i++) in_spike_times[i*TW +: TW] = TW'($urandom_range(0, 31));
      winning_neuron = NW'($urandom_range(0, 15));
      result_ready   = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    rst = 1'b0; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spike_frame_sequencer.md
SPIKE_FRAME_SEQUENCER -- requirements
Module: spike_frame_sequencer

Interface
REQ-001 SHALL have parameter NUM_SPIKES, default 16: number of input spike channels.
REQ-002 SHALL have parameter TIME_W, default 5: width of spike times and time_val.
REQ-003 SHALL have parameter TRAIN_PERIOD, default 24: cycles per training frame.
REQ-004 SHALL have parameter TEST_PERIOD, default 8: cycles per testing frame.
REQ-005 SHALL have parameter NEUR_W, default 4: winning-neuron index width.
REQ-006 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port training, input, 1: mode of the frame being offered.
REQ-009 SHALL have port in_valid, input, 1: a spike-time frame is offered.
REQ-010 SHALL have port in_ready, output, 1: the frame buffer can accept.
REQ-011 SHALL have port in_spike_times, input, NUM_SPIKES*TIME_W: per-channel spike time; channel i occupies bits [i*TIME_W +: TIME_W].
REQ-012 SHALL have port time_val, output, TIME_W: current time step within the active frame.
REQ-013 SHALL have port spikes_now, output, NUM_SPIKES: per-channel spike pulse for the current time step.
REQ-014 SHALL have port frame_active, output, 1: a frame is being played.
REQ-015 SHALL have port frame_training, output, 1: mode latched for the active frame.
REQ-016 SHALL have port winning_neuron, input, NEUR_W: layer decision.
REQ-017 SHALL have port result_valid, output, 1, and port result_ready, input, 1: test-result handshake.
REQ-018 SHALL have port result_neuron, output, NEUR_W: captured winner.
REQ-019 SHALL have port frame_count, output, 16: number of completed frames.

Function
REQ-020 SHALL accept a frame and its training bit into a one-entry buffer when in_valid and in_ready are both high; in_ready SHALL equal buffer-empty.
REQ-021 SHALL implement states IDLE, RUN and WAIT_RES.
REQ-022 IDLE with the buffer full SHALL move the frame into the active registers and enter RUN. A handshake in cycle c SHALL give frame_active=1 and time_val=0 in cycle c+2.
REQ-023 In RUN, time_val SHALL increment by 1 per cycle up to P-1. P is TRAIN_PERIOD when frame_training=1, else TEST_PERIOD.
REQ-024 spikes_now[i] SHALL be high exactly when frame_active=1 and active time[i] equals time_val; it SHALL be combinational from registers.
REQ-025 At time_val=P-1 of a testing frame, if result_valid=0 or result_ready=1, the block SHALL capture winning_neuron into result_neuron and set result_valid=1 in the next cycle.
REQ-026 If the result slot is occupied and result_ready=0 at that point, the block SHALL enter WAIT_RES: time_val holds at P-1, spikes_now=0, frame_active=1.
REQ-027 The block SHALL stay in WAIT_RES until result_ready=1, then capture winning_neuron in that cycle.
REQ-028 result_valid SHALL clear after a cycle with result_ready=1, unless a new capture occurs in the same cycle, in which case it stays 1 with the new value.
REQ-029 Training frames SHALL produce no result.
REQ-030 On frame completion, frame_count SHALL increment, wrapping from 65535 to 0.
REQ-031 On frame completion with the buffer full, the next frame SHALL start the following cycle at time_val=0, with no bubble.
REQ-032 On frame completion with the buffer empty, the block SHALL return to IDLE, with frame_active=0 and time_val=0.
REQ-033 A change of the training input mid-frame SHALL affect only frames accepted afterwards.
REQ-034 Elaboration SHALL fail unless 1 <= TEST_PERIOD and TRAIN_PERIOD <= 2**TIME_W.

Reset
REQ-035 While rst=1, the block SHALL be in IDLE, with the buffer empty, in_ready=0, and time_val, spikes_now, frame_active, frame_training, result_valid, result_neuron and frame_count all 0.
REQ-036 in_ready SHALL be 1 in the first cycle after rst falls.
REQ-037 Reset mid-frame or in WAIT_RES SHALL discard the active frame, the buffered frame and any pending result.

Configuration
REQ-038 With macro SPIKE_NO_FIRE_EN defined, a spike time of all ones SHALL mean "never spikes" for that channel.
REQ-039 Without SPIKE_NO_FIRE_EN, an all-ones time SHALL be compared normally.

Structure
REQ-040 Package stdp_seq_pkg SHALL hold the state enum and the default parameter constants.
REQ-041 The one-entry valid/ready buffer SHALL be sub-module spike_frame_buf.

Verification
REQ-042 Test 1: reset, then one testing frame with ch0=3 and ch1=7, result_ready=1 -> spikes_now[0] high at time_val=3 and [1] at time_val=7; result_valid for one cycle; frame_count=1.
REQ-043 Test 2: two training frames offered back-to-back -> time_val runs 0..23, 0..23 with no idle cycle; no result_valid.
REQ-044 Test 3: two testing frames with result_ready=0 -> second frame stalls in WAIT_RES with time_val=7; result_ready=1 releases it, and result_neuron updates to the second winner.
REQ-045 Test 4: rst pulsed at time_val=5 of a frame with the buffer full -> next cycle all outputs 0, in_ready=1 after release.
REQ-046 Test 5: channel time 31 with TIME_W=5 and TRAIN_PERIOD=32 -> no pulse when SPIKE_NO_FIRE_EN is defined, pulse at time_val=31 when not.
REQ-047 Test 6: training toggled mid-frame -> the active frame keeps its period, and the next frame uses the new mode.
